// File: rtl/cnt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cnt_arbiter
// Purpose  : Shares one CW-bit up-counter among NREQ requesters. A requester
//            raises req[i] with its terminal count on tgt[i*CW +: CW]. The
//            arbiter grants one requester at a time, round-robin. It counts
//            from 0 up to the latched target, pulses done[i] for one cycle,
//            and then releases the counter.
//
// Ports    : clk   in   rising-edge clock
//            rst   in   synchronous active-low reset
//            req   in   [NREQ]     per-requester request level (drop = abort)
//            tgt   in   [NREQ*CW]  per-requester terminal count
//            hold  in   freezes the counter while running
//            gnt   out  [NREQ]     registered one-hot grant, high for the run
//            busy  out  high while running or completing
//            cnt   out  [CW]       registered shared counter value
//            done  out  [NREQ]     registered one-cycle completion pulse
//
// Options  : CNT_ARB_PRIO0_EN - when defined, requester 0 has fixed highest
//            priority. Round-robin then rotates only over requesters
//            1..NREQ-1, and the pointer never rests on 0.
//
// Revision : 1.0  initial release
// ============================================================================
module cnt_arbiter #(
   parameter int NREQ = 4,
   parameter int CW   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*CW-1:0] tgt,
   input  logic               hold,
   output logic [NREQ-1:0]    gnt,
   output logic               busy,
   output logic [CW-1:0]      cnt,
   output logic [NREQ-1:0]    done
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;         // round-robin scan start
   logic [PW-1:0]     win_q, win_d;         // index of the current owner
   logic [CW-1:0]     tgt_lat_q, tgt_lat_d; // owner's target, frozen at grant
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              busy_q, busy_d;

   // Arbitration result, valid only while idle
   logic              pick_vld;
   logic [PW-1:0]     pick_idx;
   logic [CW-1:0]     pick_tgt;

   // -------------------------------------------------------------------------
   // Pointer that follows a finished or aborted owner: the next requester
   // in circular order. With requester 0 prioritised, 0 is never a scan
   // start, so the pointer steps over it.
   // -------------------------------------------------------------------------
   function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] w);
      logic [PW-1:0] n;
      if (w == PW'(NREQ - 1)) begin
         n = '0;
      end else begin
         n = w + PW'(1);
      end
`ifdef CNT_ARB_PRIO0_EN
      if (n == '0) begin
         n = PW'(1);
      end
`endif
      return n;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
      logic [NREQ-1:0] v;
      v = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (i == PW'(k)) begin
            v[k] = 1'b1;
         end
      end
      return v;
   endfunction

   // -------------------------------------------------------------------------
   // Winner selection: first set request at or after the pointer, wrapping.
   // -------------------------------------------------------------------------
   always_comb begin : p_pick
      int idx;
`ifdef CNT_ARB_PRIO0_EN
      int base;
`endif
      pick_vld = 1'b0;
      pick_idx = '0;
      idx      = 0;
`ifdef CNT_ARB_PRIO0_EN
      base     = 1;
      if (req[0]) begin
         pick_vld = 1'b1;
      end else begin
         // A reset pointer of 0 means "start at 1" in this mode
         base = (ptr_q == '0) ? 1 : int'(ptr_q);
         for (int k = 0; k < NREQ - 1; k++) begin
            idx = 1 + ((base - 1 + k) % (NREQ - 1));
            if (!pick_vld && req[PW'(idx)]) begin
               pick_vld = 1'b1;
               pick_idx = PW'(idx);
            end
         end
      end
`else
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!pick_vld && req[PW'(idx)]) begin
            pick_vld = 1'b1;
            pick_idx = PW'(idx);
         end
      end
`endif
   end

   // Target field of the chosen requester
   always_comb begin : p_pick_tgt
      pick_tgt = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (pick_idx == PW'(k)) begin
            pick_tgt = tgt[k*CW +: CW];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin : p_next
      state_d   = state_q;
      ptr_d     = ptr_q;
      win_d     = win_q;
      tgt_lat_d = tgt_lat_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      busy_d    = busy_q;
      done_d    = '0;

      case (state_q)
         S_IDLE: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            cnt_d  = '0;
            if (pick_vld) begin
               state_d   = S_RUN;
               win_d     = pick_idx;
               tgt_lat_d = pick_tgt;
               gnt_d     = onehot(pick_idx);
               busy_d    = 1'b1;
            end
         end

         S_RUN: begin
            if (!req[win_q]) begin
               // Owner withdrew: release without a completion pulse
               state_d = S_IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
               cnt_d   = '0;
               ptr_d   = ptr_after(win_q);
            end else if (hold) begin
               cnt_d = cnt_q;
            end else if (cnt_q == tgt_lat_q) begin
               // Terminal value reached; the counter keeps showing it
               // through the completion cycle and never wraps.
               state_d = S_DONE;
               gnt_d   = '0;
               done_d  = onehot(win_q);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
            ptr_d   = ptr_after(win_q);
         end

         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin : p_regs
      if (!rst) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         win_q     <= '0;
         tgt_lat_q <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         tgt_lat_q <= tgt_lat_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign gnt  = gnt_q;
   assign busy = busy_q;
   assign cnt  = cnt_q;
   assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cnt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnt_arbiter
// Purpose  : Self-checking bench for cnt_arbiter. The stimulus process drives
//            one cycle at a time. It advances a transaction-level reference
//            model and queues the outputs expected after the next edge. A
//            separate monitor pops one entry per edge and compares it with the
//            DUT.
// Revision : 1.0  initial release
// ============================================================================
module tb_cnt_arbiter;

   localparam int NREQ = 4;
   localparam int CW   = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req;
   logic [NREQ*CW-1:0] tgt;
   logic               hold;
   logic [NREQ-1:0]    gnt;
   logic               busy;
   logic [CW-1:0]      cnt;
   logic [NREQ-1:0]    done;

   cnt_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .tgt  (tgt),
      .hold (hold),
      .gnt  (gnt),
      .busy (busy),
      .cnt  (cnt),
      .done (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NREQ-1:0] gnt;
      logic            busy;
      logic [CW-1:0]   cnt;
      logic [NREQ-1:0] done;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_n = 0;

   // ---------------- reference model (transaction level) -------------------
   int m_owner = -1;  // -1: counter free
   int m_cnt   = 0;
   int m_tgt   = 0;
   bit m_fin   = 0;   // owner is in its completion cycle
   int m_next  = 0;   // first requester to consider at the next grant

   function automatic int model_pick(input logic [NREQ-1:0] r);
`ifdef CNT_ARB_PRIO0_EN
      int s;
      if (r[0]) return 0;
      s = (m_next == 0) ? 1 : m_next;
      for (int k = 0; k < NREQ - 1; k++) begin
         int c;
         c = 1 + ((s - 1 + k) % (NREQ - 1));
         if (r[c]) return c;
      end
      return -1;
`else
      for (int k = 0; k < NREQ; k++) begin
         int c;
         c = (m_next + k) % NREQ;
         if (r[c]) return c;
      end
      return -1;
`endif
   endfunction

   function automatic int model_follow(input int o);
      int n;
      n = (o + 1) % NREQ;
`ifdef CNT_ARB_PRIO0_EN
      if (n == 0) n = 1;
`endif
      return n;
   endfunction

   task automatic model_step(input logic r, input logic [NREQ-1:0] rq,
                             input logic [NREQ*CW-1:0] t, input logic h);
      int w;
      if (!r) begin
         m_owner = -1; m_cnt = 0; m_fin = 0; m_next = 0;
      end else if (m_owner < 0) begin
         w = model_pick(rq);
         if (w >= 0) begin
            m_owner = w;
            m_cnt   = 0;
            m_tgt   = int'(t[w*CW +: CW]);
            m_fin   = 0;
         end
      end else if (m_fin) begin
         m_next  = model_follow(m_owner);
         m_owner = -1; m_cnt = 0; m_fin = 0;
      end else if (!rq[m_owner]) begin
         m_next  = model_follow(m_owner);
         m_owner = -1; m_cnt = 0;
      end else if (h) begin
         // counter frozen
      end else if (m_cnt == m_tgt) begin
         m_fin = 1;
      end else begin
         m_cnt = m_cnt + 1;
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.gnt  = '0;
      e.done = '0;
      e.busy = (m_owner >= 0);
      e.cnt  = CW'(m_cnt);
      if (m_owner >= 0 && !m_fin) e.gnt[m_owner]  = 1'b1;
      if (m_owner >= 0 &&  m_fin) e.done[m_owner] = 1'b1;
      return e;
   endfunction

   // ---------------- checking ----------------------------------------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         edge_n++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("gnt",  32'(gnt),  32'(e.gnt));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("cnt",  32'(cnt),  32'(e.cnt));
            chk("done", 32'(done), 32'(e.done));
         end
      end
   end

   // ---------------- stimulus -----------------------------------------------
   logic [NREQ-1:0]    req_v  = '0;
   logic [NREQ*CW-1:0] tgt_v  = '0;
   bit                 autodrop = 1;

   // Drive one cycle, predict the next edge, and advance past it
   task automatic cyc(input logic r, input logic h);
      rst  = r;
      req  = req_v;
      tgt  = tgt_v;
      hold = h;
      model_step(r, req_v, tgt_v, h);
      sb.push_back(model_out());
      // A requester lets go once its completion is signalled
      if (autodrop && m_owner >= 0 && m_fin) req_v[m_owner] = 1'b0;
      @(posedge clk);
      #3;
   endtask

   initial begin : stim
      // Reset
      req_v = '0; tgt_v = '0;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);

      // Single run: requester 1, target 5
      req_v = 4'b0010;
      tgt_v[7:4] = 4'd5;
      for (int n = 0; n < 10; n++) cyc(1'b1, 1'b0);

      // Hold: requester 0, target 3, counter frozen two cycles at 2
      req_v = 4'b0001;
      tgt_v = '0;
      tgt_v[3:0] = 4'd3;
      for (int n = 1; n <= 10; n++) cyc(1'b1, (n == 4 || n == 5));

      // Abort: requester 2 (target 9) drops at count 3; requester 3 waits
      req_v = 4'b1100;
      tgt_v[11:8]  = 4'd9;
      tgt_v[15:12] = 4'd2;
      for (int n = 1; n <= 12; n++) begin
         if (n == 5) req_v[2] = 1'b0;
         cyc(1'b1, 1'b0);
      end

      // Reset mid-run with requesters 1 and 3 pending
      req_v = 4'b1010;
      tgt_v[7:4]   = 4'd10;
      tgt_v[15:12] = 4'd10;
      for (int n = 1; n <= 8; n++) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      for (int n = 0; n < 30; n++) cyc(1'b1, 1'b0);

      // Boundary: maximum target, no wrap
      req_v = 4'b0001;
      tgt_v = '1;
      for (int n = 0; n < 20; n++) cyc(1'b1, 1'b0);

      // Round-robin with all requests held and zero targets
      autodrop = 0;
      tgt_v = '0;
      for (int n = 0; n < 16; n++) begin
         req_v = '1;
         cyc(1'b1, 1'b0);
      end
      req_v = '0;
      for (int n = 0; n < 4; n++) cyc(1'b1, 1'b0);
      autodrop = 1;

      // Randomised traffic; targets change every cycle to exercise latching
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_v[i]) begin
               if ($urandom % 4 == 0) req_v[i] = 1'b1;
            end else if ($urandom % 60 == 0) begin
               req_v[i] = 1'b0;
            end
            tgt_v[i*CW +: CW] = ($urandom % 8 == 0) ? CW'(15) : CW'($urandom_range(0, 6));
         end
         cyc(($urandom % 250) != 0, ($urandom % 5) == 0);
      end

      req_v = '0;
      for (int n = 0; n < 4; n++) cyc(1'b1, 1'b0);

      @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cnt_arbiter.md
# cnt_arbiter

Shares one CW-bit up-counter among NREQ requesters. Each requester asks for a counting run to its own terminal value. The block grants one requester at a time, round-robin, and sequences the counter from 0 to the latched target. On completion it pulses a per-requester done and releases the counter. It sits between the timer-using client blocks and the shared counter datapath.

## Interface
- NREQ, 4: number of requesters (2..8)
- CW, 4: counter width in bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset; sampled on clk rising edge
- req  input  NREQ  per-requester request level; held high until done, or dropped to abort
- tgt  input  NREQ*CW  per-requester terminal count; requester i uses bits [i*CW +: CW]
- hold  input  1  freezes the counter while in RUN
- gnt  output  NREQ  one-hot grant, registered; high for the whole run
- busy  output  1  high in RUN and DONE
- cnt  output  CW  shared counter value, registered
- done  output  NREQ  one-cycle completion pulse, registered, one-hot

## Operation
- Reset (rst=0 at an edge): state=IDLE, gnt=0, done=0, busy=0, cnt=0, round-robin pointer ptr=0. Reset overrides every other input, including mid-run; no done is issued.
- State machine: IDLE, RUN, DONE.
- IDLE
  - If req≠0, pick the first set req bit scanning from ptr upward, modulo NREQ.
  - Next cycle: gnt=onehot(winner), state=RUN, cnt=0, busy=1.
  - Latch tgt of the winner into an internal register. Later tgt changes are ignored.
  - If req=0, stay in IDLE with all outputs 0.
- RUN, in priority order:
  - req[winner]=0: abort. Next cycle IDLE, gnt=0, busy=0, cnt=0, no done, ptr=winner+1.
  - hold=1: cnt holds.
  - cnt==latched target: next cycle DONE, gnt=0, done[winner]=1, cnt holds at target.
  - Otherwise: cnt=cnt+1.
- DONE: one cycle. Next cycle IDLE, done=0, busy=0, cnt=0, ptr=(winner+1) mod NREQ.
- Arithmetic
  - cnt never wraps; the maximum target 2^CW-1 completes at all-ones.
  - A target of 0 completes after one RUN cycle.
  - Round-robin wrap: ptr=NREQ-1 plus 1 gives ptr=0.
- A requester whose req is high in DONE or IDLE competes normally. Back-to-back runs by the same requester are allowed if no other requester is waiting.

## Timing
- req[i] rises in IDLE at edge k, hold=0 throughout:
  - gnt[i]=1 and cnt=0 from edge k+1.
  - cnt=T at edge k+1+T.
  - done[i]=1 and gnt=0 at edge k+2+T.
  - IDLE at edge k+3+T.
  - Earliest next gnt at edge k+4+T.
- Each cycle of hold=1 in RUN adds exactly one cycle to every later timestamp.
- An abort seen at edge m gives gnt=0 at edge m+1.
- All outputs are registered. No combinational path from input to output.

## Configuration
- CNT_ARB_PRIO0_EN
  - Defined: requester 0 has fixed highest priority. In IDLE, req[0]=1 always wins. The round-robin scan from ptr applies only to requesters 1..NREQ-1, and ptr skips 0.
  - Undefined: pure round-robin over all requesters as described above.

## Test plan
- Single run: req=4'b0010, tgt[7:4]=5
  - gnt=4'b0010 at edge 1.
  - cnt runs 0..5 over edges 1..6.
  - done=4'b0010 at edge 7 only.
  - IDLE, all outputs 0, at edge 8.
- Round robin: req=4'b1111 held, all targets 0
  - Grants in order 0,1,2,3,0, three cycles apart.
  - Done pulses follow the same order.
  - With CNT_ARB_PRIO0_EN defined: grants go 0,0,0…
- Hold: target 3, hold=1 for 2 cycles while cnt=2
  - cnt stays 2 for three edges.
  - done delayed by 2 cycles versus the baseline of edge 5.
- Abort: req[2] dropped while cnt=3, target 9
  - gnt=0, cnt=0 next cycle, no done.
  - A pending req[3] granted next, since ptr=3.
- Reset mid-run: rst=0 for one edge at cnt=7
  - gnt=0, cnt=0, done=0, busy=0.
  - After rst=1, pending req[1] and req[3] are granted to requester 1 first, since ptr=0.
- Boundary: tgt=15 (CW=4)
  - cnt reaches 4'hF, done follows, no wrap to 0 before DONE.
